// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern sequencer.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'd0,
        MODE_COUNT  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Init patterns are either all-zeros or a single lit bit 0.
    function automatic logic init_lit(mode_t m);
        return (m == MODE_CHASE) || (m == MODE_BOUNCE);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler; tick marks the last count of each 2^DIV_BITS period.
module tick_gen #(
    parameter int DIV_BITS = 21
) (
    input  logic CLK_12_MHZ,
    input  logic RST,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    logic [DIV_BITS-1:0] count;

    always_ff @(posedge CLK_12_MHZ or posedge RST) begin
        if (RST)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + DIV_BITS'(1);
    end

    // A pending clear (mode change) swallows the tick of that cycle.
    assign tick = enable && !clear && (&count);

endmodule

// File: rtl/led_sequencer.sv
// Pattern generator for a row of LEDs; advances one pattern step per prescaler period.
module led_sequencer
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int DIV_BITS = 21
) (
    input  logic                CLK_12_MHZ,
    input  logic                RST,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] leds,
    output logic                step
);

    mode_t               mode_in, mode_q;
    dir_t                dir_q, dir_d;
    logic [NUM_LEDS-1:0] leds_d;
    logic                mode_chg;
    logic                tick;

    assign mode_in  = mode_t'(mode);
    assign mode_chg = (mode_in != mode_q);

    tick_gen #(
        .DIV_BITS(DIV_BITS)
    ) u_tick (
        .CLK_12_MHZ(CLK_12_MHZ),
        .RST       (RST),
        .enable    (enable),
        .clear     (mode_chg),
        .tick      (tick)
    );

    always_ff @(posedge CLK_12_MHZ or posedge RST) begin
        if (RST) begin
            mode_q <= MODE_SHIFT;
            dir_q  <= DIR_UP;
            leds   <= '0;
        end else begin
            mode_q <= mode_in;
            dir_q  <= dir_d;
            leds   <= leds_d;
        end
    end

    // Mode change wins over a coincident tick and loads regardless of enable.
    always_comb begin
        leds_d = leds;
        dir_d  = dir_q;
        if (mode_chg) begin
            leds_d = {{(NUM_LEDS-1){1'b0}}, init_lit(mode_in)};
            dir_d  = DIR_UP;
        end else if (tick) begin
            case (mode_q)
                MODE_SHIFT:  leds_d = {leds[NUM_LEDS-2:0], ~leds[0]};
                MODE_COUNT:  leds_d = leds + NUM_LEDS'(1);
                MODE_CHASE:  leds_d = {leds[NUM_LEDS-2:0], leds[NUM_LEDS-1]};
                MODE_BOUNCE: begin
                    // At an end the step reverses and moves away; it never holds.
                    if (dir_q == DIR_UP) begin
                        if (leds[NUM_LEDS-1]) begin
                            dir_d  = DIR_DOWN;
                            leds_d = leds >> 1;
                        end else begin
                            leds_d = leds << 1;
                        end
                    end else begin
                        if (leds[0]) begin
                            dir_d  = DIR_UP;
                            leds_d = leds << 1;
                        end else begin
                            leds_d = leds >> 1;
                        end
                    end
                end
                default: leds_d = leds;
            endcase
        end
    end

    always_comb begin
        step = tick;
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed checks of led_sequencer at 4 LEDs / DIV_BITS=2 and at 8 LEDs / DIV_BITS=3.
module tb_led_sequencer;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [1:0] mode;
    logic [3:0] leds4;
    logic       step4;
    logic       rst8, en8;
    logic [1:0] mode8;
    logic [7:0] leds8;
    logic       step8;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    led_sequencer #(.NUM_LEDS(4), .DIV_BITS(2)) dut4 (
        .CLK_12_MHZ(clk), .RST(rst), .enable(en), .mode(mode),
        .leds(leds4), .step(step4)
    );

    led_sequencer #(.NUM_LEDS(8), .DIV_BITS(3)) dut8 (
        .CLK_12_MHZ(clk), .RST(rst8), .enable(en8), .mode(mode8),
        .leds(leds8), .step(step8)
    );

    typedef struct {
        logic [1:0] mode;
        int         gap;
        logic [3:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge; step must appear only in cycle n.
    task automatic expect_step_after(input string name, input int n, input logic [3:0] exp);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            check({name, "_step"}, 32'(step4), 32'(i == n));
        end
        @(posedge clk); #1;
        check({name, "_leds"}, 32'(leds4), 32'(exp));
    endtask

    task automatic change_mode(input string name, input logic [1:0] m, input logic [3:0] exp_init);
        mode = m;
        @(negedge clk);
        check({name, "_nostep"}, 32'(step4), 32'd0);
        @(posedge clk); #1;
        check({name, "_init"}, 32'(leds4), 32'(exp_init));
    endtask

    function automatic logic [3:0] init_of(input logic [1:0] m);
        return (m >= 2'd2) ? 4'b0001 : 4'b0000;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tbl[31];
        logic [7:0] chase8[8];
        logic [1:0] cur;

        tbl[0]  = '{2'd0, 4, 4'b0001};
        tbl[1]  = '{2'd0, 4, 4'b0010};
        tbl[2]  = '{2'd0, 4, 4'b0101};
        tbl[3]  = '{2'd0, 4, 4'b1010};
        tbl[4]  = '{2'd1, 4, 4'b0001};
        tbl[5]  = '{2'd1, 4, 4'b0010};
        tbl[6]  = '{2'd1, 4, 4'b0011};
        tbl[7]  = '{2'd1, 4, 4'b0100};
        tbl[8]  = '{2'd1, 4, 4'b0101};
        tbl[9]  = '{2'd1, 4, 4'b0110};
        tbl[10] = '{2'd1, 4, 4'b0111};
        tbl[11] = '{2'd1, 4, 4'b1000};
        tbl[12] = '{2'd1, 4, 4'b1001};
        tbl[13] = '{2'd1, 4, 4'b1010};
        tbl[14] = '{2'd1, 4, 4'b1011};
        tbl[15] = '{2'd1, 4, 4'b1100};
        tbl[16] = '{2'd1, 4, 4'b1101};
        tbl[17] = '{2'd1, 4, 4'b1110};
        tbl[18] = '{2'd1, 4, 4'b1111};
        tbl[19] = '{2'd1, 4, 4'b0000};
        tbl[20] = '{2'd1, 4, 4'b0001};
        tbl[21] = '{2'd3, 4, 4'b0010};
        tbl[22] = '{2'd3, 4, 4'b0100};
        tbl[23] = '{2'd3, 4, 4'b1000};
        tbl[24] = '{2'd3, 4, 4'b0100};
        tbl[25] = '{2'd3, 4, 4'b0010};
        tbl[26] = '{2'd3, 4, 4'b0001};
        tbl[27] = '{2'd3, 4, 4'b0010};
        tbl[28] = '{2'd3, 4, 4'b0100};
        tbl[29] = '{2'd2, 4, 4'b0010};
        tbl[30] = '{2'd2, 4, 4'b0100};
        chase8  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

        rst = 1'b1; en = 1'b0; mode = 2'd0;
        rst8 = 1'b1; en8 = 1'b0; mode8 = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_leds", 32'(leds4), 32'd0);
        check("reset_step", 32'(step4), 32'd0);

        @(posedge clk); #1;
        rst = 1'b0; en = 1'b1;
        cur = 2'd0;
        for (int i = 0; i < 31; i++) begin
            if (tbl[i].mode != cur) begin
                change_mode($sformatf("chg%0d", i), tbl[i].mode, init_of(tbl[i].mode));
                cur = tbl[i].mode;
            end
            expect_step_after($sformatf("vec%0d", i), tbl[i].gap, tbl[i].exp);
        end

        // CHASE at 0100: switch to COUNT inside the step cycle.
        repeat (3) @(posedge clk);
        #1 mode = 2'd1;
        @(negedge clk);
        check("coinc_step", 32'(step4), 32'd0);
        @(posedge clk); #1;
        check("coinc_leds", 32'(leds4), 32'd0);
        check("coinc_presc", 32'(dut4.u_tick.count), 32'd0);
        expect_step_after("coinc_next", 4, 4'b0001);

        // Mode change part-way through a period must restart the prescaler.
        repeat (2) @(posedge clk);
        #1 mode = 2'd2;
        @(negedge clk);
        check("mid_step", 32'(step4), 32'd0);
        @(posedge clk); #1;
        check("mid_leds", 32'(leds4), 32'd1);
        check("mid_presc", 32'(dut4.u_tick.count), 32'd0);
        expect_step_after("mid_next", 4, 4'b0010);

        // Freeze with prescaler at 1, then resume: 3 more cycles to the step.
        @(posedge clk); #1;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("freeze%0d_step", i), 32'(step4), 32'd0);
            check($sformatf("freeze%0d_leds", i), 32'(leds4), 32'b0010);
        end
        check("freeze_presc", 32'(dut4.u_tick.count), 32'd1);
        @(posedge clk); #1;
        en = 1'b1;
        expect_step_after("resume", 3, 4'b0100);

        // Asynchronous reset mid-cycle, released with a non-SHIFT mode waiting.
        #3 rst = 1'b1;
        #1;
        check("async_leds", 32'(leds4), 32'd0);
        check("async_step", 32'(step4), 32'd0);
        check("async_presc", 32'(dut4.u_tick.count), 32'd0);
        mode = 2'd3;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_bounce_nostep", 32'(step4), 32'd0);
        @(posedge clk); #1;
        check("rst_bounce_init", 32'(leds4), 32'b0001);
        expect_step_after("rst_bounce", 4, 4'b0010);

        // Mode change still loads while disabled.
        en = 1'b0;
        change_mode("dis_chg", 2'd1, 4'b0000);
        @(negedge clk);
        check("dis_hold_step", 32'(step4), 32'd0);
        @(posedge clk); #1;
        en = 1'b1;
        expect_step_after("dis_resume", 4, 4'b0001);

        // 8 LEDs, DIV_BITS=3, CHASE.
        rst8 = 1'b0; en8 = 1'b1; mode8 = 2'd2;
        @(negedge clk);
        check("w8_chg_step", 32'(step8), 32'd0);
        @(posedge clk); #1;
        check("w8_init", 32'(leds8), 32'h01);
        for (int k = 0; k < 8; k++) begin
            for (int i = 1; i <= 8; i++) begin
                @(negedge clk);
                check($sformatf("w8_%0d_step", k), 32'(step8), 32'(i == 8));
            end
            @(posedge clk); #1;
            check($sformatf("w8_%0d_leds", k), 32'(leds8), 32'(chase8[k]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4, giving the number of LED outputs; legal range 2..32.
REQ-002 SHALL have parameter DIV_BITS, default 21, giving the prescaler width; step period is 2^DIV_BITS clocks; legal range 1..31.
REQ-003 SHALL have port CLK_12_MHZ, input, 1 bit: the single system clock; all state on rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port enable, input, 1 bit: 1 = run, 0 = freeze prescaler and pattern.
REQ-006 SHALL have port mode, input, 2 bits: pattern select, 0 = SHIFT, 1 = COUNT, 2 = CHASE, 3 = BOUNCE.
REQ-007 SHALL have port leds, output, NUM_LEDS bits: registered LED drive, bit 0 = first LED.
REQ-008 SHALL have port step, output, 1 bit: one-cycle pulse in the cycle the pattern advances.

Function
REQ-009 SHALL derive timing from a DIV_BITS-bit prescaler counter clocked by CLK_12_MHZ; no derived or gated clocks.
REQ-010 SHALL increment the prescaler by 1 each cycle enable=1 and wrap from all-ones to 0.
REQ-011 SHALL assert step for exactly one cycle when enable=1 and prescaler is all-ones; step=0 otherwise.
REQ-012 SHALL update leds in the cycle after step is asserted, so leds change one clock after the step pulse.
REQ-013 SHALL, in SHIFT mode on each step, toggle leds[0] and set leds[i] to the old leds[i-1] for i>=1.
REQ-014 SHALL, in COUNT mode on each step, set leds to leds+1 modulo 2^NUM_LEDS, wrapping from all-ones to 0.
REQ-015 SHALL, in CHASE mode on each step, rotate leds left by one, MSB wrapping to bit 0.
REQ-016 SHALL, in BOUNCE mode, hold a direction bit (UP = toward MSB, DOWN = toward bit 0) and shift the single lit bit one place in that direction on each step.
REQ-017 SHALL, in BOUNCE mode on a step, reverse direction and move away from the end when the lit bit is at the MSB with UP or at bit 0 with DOWN; no step holds at an end.
REQ-018 SHALL store the registered mode; when mode differs from it, next cycle SHALL load that mode's init pattern, clear the prescaler, update the registered mode, and suppress step that cycle.
REQ-019 SHALL use these init patterns: SHIFT all-zeros; COUNT all-zeros; CHASE 0..01; BOUNCE 0..01 with direction UP.
REQ-020 SHALL give a mode change priority over a coincident step, so the init pattern loads, not an advanced pattern.
REQ-021 SHALL, when enable=0, hold prescaler, leds and direction, and keep step=0; a mode change still loads init while disabled.
REQ-022 SHALL, when enable returns to 1, resume counting from the held prescaler value with no extra step.

Reset
REQ-023 SHALL, while RST=1 (asynchronously), force prescaler=0, leds=all-zeros, step=0, registered mode=SHIFT, direction=UP.
REQ-024 SHALL, at the first clock after RST deasserts, treat a non-SHIFT mode input as a mode change per REQ-018.
REQ-025 SHALL abort any pattern in progress on RST asserted mid-operation, with no residual state kept.

Structure
REQ-026 SHALL take mode encodings (SHIFT/COUNT/CHASE/BOUNCE) and the direction encoding from a shared package, led_pkg.
REQ-027 SHALL put the prescaler and step generation in one sub-module, tick_gen, with parameter DIV_BITS and ports CLK_12_MHZ, RST, enable, clear, tick.
REQ-028 SHALL keep the pattern state machine and mode register in led_sequencer.

Verification (NUM_LEDS=4, DIV_BITS=2 unless stated)
REQ-029 SHALL cover reset and tick: RST pulse, then enable=1, mode=SHIFT -> step high on cycles 4, 8, 12; leds 0001, 0010, 0101, 1010 after successive steps.
REQ-030 SHALL cover COUNT wrap: COUNT for 17 steps -> leds 0001..1111, then 0000, then 0001.
REQ-031 SHALL cover BOUNCE reversal: BOUNCE for 8 steps -> leds 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100.
REQ-032 SHALL cover mode change coincident with step: CHASE at 0100, switch to COUNT in the step cycle -> leds=0000, prescaler=0, no step that cycle, next step 4 cycles later.
REQ-033 SHALL cover freeze and async reset: enable=0 for 10 cycles mid-pattern -> leds and step unchanged; then RST mid-cycle -> leds=0000 before the next clock edge.
REQ-034 SHALL cover scaling: NUM_LEDS=8, DIV_BITS=3, CHASE -> step every 8 cycles; 10000000 rotates to 00000001.
